// File: rtl/simple_pkg.sv
// Shared definitions for the serial transmitter and its companion sequence FSM:
// state encoding, default word/gap sizes and a small elaboration helper.
package simple_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t SEND = 2'b01;
    localparam state_t GAP  = 2'b10;

    localparam int WIDTH_DEF      = 8;
    localparam int GAP_CYCLES_DEF = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/simple_tx.sv
// Serial transmitter: accepts a parallel word over valid/ready, shifts it out LSB-first
// one bit per clock, then holds the line low for a guard gap before accepting again.
module simple_tx
    import simple_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             tx_bit,
    output logic             tx_active,
    output logic [1:0]       state,
    output logic             done
);

    localparam int CNT_W = $clog2(max_int(WIDTH, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP_CYCLES - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   gap_nxt;
    logic               tx_bit_q, tx_bit_d;
    logic               tx_active_q, tx_active_d;
    logic               done_q, done_d;
    logic               accept;

    assign data_ready = (state_q == IDLE);
    assign accept     = data_valid & data_ready;
    assign gap_nxt    = gap_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        tx_bit_d    = 1'b0;
        tx_active_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d     = data_in;
                    tx_bit_d    = data_in[0];
                    bit_cnt_d   = '0;
                    tx_active_d = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                    done_d    = (LAST_GAP == '0);
                end else begin
                    // tx_bit holds shreg[0]; the register shifts so the next bit lands there
                    shreg_d     = shreg_q >> 1;
                    tx_bit_d    = shreg_d[0];
                    bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                    tx_active_d = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == LAST_GAP) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_nxt;
                    done_d    = (gap_nxt == LAST_GAP);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            tx_bit_q    <= 1'b0;
            tx_active_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_active_q <= tx_active_d;
            done_q      <= done_d;
        end
    end

    assign state     = state_q;
    assign tx_bit    = tx_bit_q;
    assign tx_active = tx_active_q;
    assign done      = done_q;

endmodule

// File: tb/tb_simple_tx.sv
// Scoreboard bench for simple_tx: each accepted word expands into its expected per-cycle
// line activity, which an independent monitor compares against the DUT on every falling edge.
module tb_simple_tx;
    import simple_pkg::*;

    localparam int W = 8;
    localparam int G = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         data_ready;
    logic         tx_bit;
    logic         tx_active;
    logic [1:0]   state;
    logic         done;

    simple_tx #(.WIDTH(W), .GAP_CYCLES(G)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx_bit     (tx_bit),
        .tx_active  (tx_active),
        .state      (state),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic       b;
        logic       act;
        logic       dn;
        logic [1:0] st;
    } rec_t;

    rec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, req);
    endtask

    // Expected line activity of one word: W data bits in SEND, then G low cycles in GAP,
    // with done marking the last of them.
    function automatic void push_word(input logic [W-1:0] w);
        rec_t r;
        for (int i = 0; i < W; i++) begin
            r.b = w[i]; r.act = 1'b1; r.dn = 1'b0; r.st = SEND;
            exp_q.push_back(r);
        end
        for (int g = 0; g < G; g++) begin
            r.b = 1'b0; r.act = 1'b0; r.dn = (g == G - 1); r.st = GAP;
            exp_q.push_back(r);
        end
    endfunction

    // Monitor: compares {tx_bit, tx_active, done, state} and data_ready every cycle.
    initial begin : monitor
        rec_t e;
        rec_t a;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else begin
                    e.b = 1'b0; e.act = 1'b0; e.dn = 1'b0; e.st = IDLE;
                end
                a = {tx_bit, tx_active, done, state};
                check("line{bit,act,done,state}", 32'(a), 32'(e));
                check("data_ready", 32'(data_ready), 32'(e.st == IDLE));
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge following accept.
    task automatic send_word(input logic [W-1:0] w, output int acc_cycle);
        data_in    = w;
        data_valid = 1'b1;
        acc_cycle  = -1;
        for (int t = 0; t < 100; t++) begin
            if (data_ready) begin
                push_word(w);
                acc_cycle = cycle;
                @(negedge clk); #1;
                return;
            end
            @(negedge clk); #1;
        end
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk); #1;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk); #1;
    endtask

    initial begin : driver
        int a1, a2;
        logic [W-1:0] w;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_tx_bit", 32'(tx_bit), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tx_active", 32'(tx_active), 32'd0);
        #1 reset_n = 1'b1;
        #1 check("rst_ready", 32'(data_ready), 32'd1);
        @(negedge clk); #1;

        // Single word
        send_word(8'hA5, a1);
        data_valid = 1'b0;
        drain();

        // Back-to-back with valid held high
        send_word(8'hFF, a1);
        send_word(8'h01, a2);
        data_valid = 1'b0;
        check("b2b_spacing", 32'(a2 - a1), 32'd11);
        drain();

        // Valid pulsed with new data mid-SEND is ignored
        send_word(8'h3C, a1);
        data_valid = 1'b0;
        repeat (2) begin @(negedge clk); #1; end
        data_in    = 8'h00;
        data_valid = 1'b1;
        @(negedge clk); #1;
        data_valid = 1'b0;
        drain();

        // Reset during the 4th bit of 8'hFF
        send_word(8'hFF, a1);
        data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_tx_bit", 32'(tx_bit), 32'd0);
        check("midrst_tx_active", 32'(tx_active), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_state", 32'(state), 32'(IDLE));
        repeat (2) begin @(negedge clk); #1; end
        reset_n = 1'b1;
        @(negedge clk); #1;
        send_word(8'h81, a1);
        data_valid = 1'b0;
        drain();

        // Randomised words, mixing back-to-back and idle spacing
        for (int k = 0; k < 30; k++) begin
            w = W'($urandom);
            send_word(w, a1);
            if ($urandom_range(0, 1) == 0) begin
                data_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
            end
        end
        data_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
